// File: rtl/reg_loc_table.sv
// Rename-stage register location table (ARF vs ROB tag) with in-group bypass; reads 0-cycle, updates 1-cycle.
// No handshake: i_stall_rn blocks rename writes only, commit release and recover always apply.
module reg_loc_table #(
    parameter int WIDTH  = 2,
    parameter int NREG   = 32,
    parameter int LREG_W = 5,
    parameter int TAG_W  = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_stall_rn,
    input  logic                        i_recover,
    input  logic [2*WIDTH*LREG_W-1:0]   i_src_l,
    input  logic [WIDTH*LREG_W-1:0]     i_rd_l,
    input  logic [WIDTH-1:0]            i_rd_en,
    input  logic [WIDTH*TAG_W-1:0]      i_rn_tag,
    input  logic [WIDTH*LREG_W-1:0]     i_cm_rd_l,
    input  logic [WIDTH-1:0]            i_cm_en,
    input  logic [WIDTH*TAG_W-1:0]      i_cm_tag,
    output logic [2*WIDTH-1:0]          o_src_in_rob,
    output logic [2*WIDTH*TAG_W-1:0]    o_src_tag,
    output logic [LREG_W:0]             o_rob_cnt
);

    localparam int NSRC = 2 * WIDTH;

    logic [NREG-1:0]   r_loc;
    logic [TAG_W-1:0]  r_tag [NREG];
    logic [LREG_W:0]   r_cnt;

    logic [NREG-1:0]   w_loc_nxt;
    logic [TAG_W-1:0]  w_tag_nxt [NREG];
    logic [LREG_W:0]   w_cnt_nxt;
    logic [LREG_W:0]   w_set;
    logic [LREG_W:0]   w_clr;

    logic [NSRC-1:0]   w_src_hit;
    logic [TAG_W-1:0]  w_src_tag [NSRC];

    // Source lookup: stored mapping, overridden by the youngest older slot in the group writing it.
    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            w_src_hit[k] = r_loc[i_src_l[k*LREG_W +: LREG_W]];
            w_src_tag[k] = r_tag[i_src_l[k*LREG_W +: LREG_W]];
            for (int j = 0; j < k / 2; j++) begin
                if (i_rd_en[j] && (i_rd_l[j*LREG_W +: LREG_W] != '0) &&
                    (i_rd_l[j*LREG_W +: LREG_W] == i_src_l[k*LREG_W +: LREG_W])) begin
                    w_src_hit[k] = 1'b1;
                    w_src_tag[k] = i_rn_tag[j*TAG_W +: TAG_W];
                end
            end
            if (i_src_l[k*LREG_W +: LREG_W] == '0) begin
                w_src_hit[k] = 1'b0;
            end
            if (!w_src_hit[k]) begin
                w_src_tag[k] = '0;
            end
        end
    end

    always_comb begin
        o_src_in_rob = '0;
        o_src_tag    = '0;
        for (int k = 0; k < NSRC; k++) begin
            o_src_in_rob[k]             = w_src_hit[k];
            o_src_tag[k*TAG_W +: TAG_W] = w_src_tag[k];
        end
    end

    // Commit is applied first so a same-edge rename of the same register overrides it.
    always_comb begin
        w_loc_nxt = r_loc;
        for (int r = 0; r < NREG; r++) begin
            w_tag_nxt[r] = r_tag[r];
        end
        if (i_recover) begin
            w_loc_nxt = '0;
            for (int r = 0; r < NREG; r++) begin
                w_tag_nxt[r] = '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    if (i_cm_en[c] && (i_cm_rd_l[c*LREG_W +: LREG_W] == LREG_W'(r)) &&
                        r_loc[r] && (r_tag[r] == i_cm_tag[c*TAG_W +: TAG_W])) begin
                        w_loc_nxt[r] = 1'b0;
                    end
                end
                if (!i_stall_rn) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (i_rd_en[j] && (i_rd_l[j*LREG_W +: LREG_W] == LREG_W'(r))) begin
                            w_loc_nxt[r] = 1'b1;
                            w_tag_nxt[r] = i_rn_tag[j*TAG_W +: TAG_W];
                        end
                    end
                end
            end
        end
    end

    // Count tracks only location transitions, so re-renaming a mapped entry leaves it unchanged.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 0; r < NREG; r++) begin
            if (!r_loc[r] && w_loc_nxt[r]) begin
                w_set = w_set + (LREG_W+1)'(1);
            end
            if (r_loc[r] && !w_loc_nxt[r]) begin
                w_clr = w_clr + (LREG_W+1)'(1);
            end
        end
        w_cnt_nxt = i_recover ? '0 : (r_cnt + w_set - w_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loc <= '0;
            for (int r = 0; r < NREG; r++) begin
                r_tag[r] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_loc <= w_loc_nxt;
            for (int r = 0; r < NREG; r++) begin
                r_tag[r] <= w_tag_nxt[r];
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_rob_cnt = r_cnt;

endmodule
